// File: rtl/ls373_latch_seq.sv
// ---------------------------------------------------------------------------
// ls373_latch_seq
//   Load/drive sequencer for a 74S373 octal transparent latch. A byte taken
//   on a req edge walks through a fixed sequence:
//     data setup -> latch open -> latch close -> output drive -> turnaround.
//   The sequence never pulls OENB_N low while HOLD_N is high.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   load request, sampled only while idle
//   din[7:0] in   byte to load, sampled on the accepting edge
//   busy     out  high in every state except IDLE
//   ack      out  one-cycle pulse in the last DRIVE cycle
//   i_out    out  to latch I7..I0, registered copy of the accepted byte
//   hold_n   out  to latch HOLD_N (1 = transparent)
//   oenb_n   out  to latch OENB_N (0 = outputs driven)
//
// Every output is a flop. Outputs are decoded from the next state, so each
// output register changes on the same edge that the state register does.
// ---------------------------------------------------------------------------
module ls373_latch_seq #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned OPEN_CYC  = 2,
    parameter int unsigned DRIVE_CYC = 4,
    parameter int unsigned TURN_CYC  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [7:0] din,
    output logic       busy,
    output logic       ack,
    output logic [7:0] i_out,
    output logic       hold_n,
    output logic       oenb_n
);

    // Durations are clamped into 1..15 so the 4-bit counter load is always
    // meaningful; a zero duration behaves like one cycle.
    localparam int unsigned SETUP_N = (SETUP_CYC == 0) ? 1 : ((SETUP_CYC > 15) ? 15 : SETUP_CYC);
    localparam int unsigned OPEN_N  = (OPEN_CYC  == 0) ? 1 : ((OPEN_CYC  > 15) ? 15 : OPEN_CYC);
    localparam int unsigned DRIVE_N = (DRIVE_CYC == 0) ? 1 : ((DRIVE_CYC > 15) ? 15 : DRIVE_CYC);
    localparam int unsigned TURN_N  = (TURN_CYC  == 0) ? 1 : ((TURN_CYC  > 15) ? 15 : TURN_CYC);

    localparam logic [3:0] SETUP_LD = 4'(SETUP_N - 1);
    localparam logic [3:0] OPEN_LD  = 4'(OPEN_N  - 1);
    localparam logic [3:0] DRIVE_LD = 4'(DRIVE_N - 1);
    localparam logic [3:0] TURN_LD  = 4'(TURN_N  - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_OPEN  = 3'd2,
        S_CLOSE = 3'd3,
        S_DRIVE = 3'd4,
        S_TURN  = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] i_out_q, i_out_d;
    logic       hold_n_q, hold_n_d;
    logic       oenb_n_q, oenb_n_d;
    logic       busy_q,   busy_d;
    logic       ack_q,    ack_d;
    logic       cnt_done;

    assign cnt_done = (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            i_out_q  <= 8'h00;
            hold_n_q <= 1'b0;
            oenb_n_q <= 1'b1;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            i_out_q  <= i_out_d;
            hold_n_q <= hold_n_d;
            oenb_n_q <= oenb_n_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q - 4'd1;
        i_out_d  = i_out_q;
        hold_n_d = 1'b0;
        oenb_n_d = 1'b1;
        busy_d   = 1'b0;
        ack_d    = 1'b0;

        // Each timed state loads its duration minus one on entry and leaves
        // on the edge where the counter has reached zero.
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (req) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    i_out_d = din;
                end
            end
            S_SETUP: if (cnt_done) begin
                state_d = S_OPEN;
                cnt_d   = OPEN_LD;
            end
            S_OPEN: if (cnt_done) begin
                state_d = S_CLOSE;
                cnt_d   = 4'd0;
            end
            // CLOSE is a single hold-time cycle after HOLD_N falls.
            S_CLOSE: begin
                state_d = S_DRIVE;
                cnt_d   = DRIVE_LD;
            end
            S_DRIVE: if (cnt_done) begin
                state_d = S_TURN;
                cnt_d   = TURN_LD;
            end
            S_TURN: if (cnt_done) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            // Unreachable encodings recover to IDLE with reset-valued outputs.
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                i_out_d = 8'h00;
            end
        endcase

        // Registered outputs follow the state being entered.
        hold_n_d = (state_d == S_OPEN);
        oenb_n_d = (state_d != S_DRIVE);
        busy_d   = (state_d != S_IDLE);
        ack_d    = (state_d == S_DRIVE) && (cnt_d == 4'd0);
    end

    assign busy   = busy_q;
    assign ack    = ack_q;
    assign i_out  = i_out_q;
    assign hold_n = hold_n_q;
    assign oenb_n = oenb_n_q;

endmodule
